// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: forwarding select encoding
// and default widths.
package hazard_forward_unit_pkg;

    localparam int unsigned NB_REG_ADDR_DEFAULT  = 5;
    localparam int unsigned NB_FWD_SEL           = 2;
    localparam int unsigned NB_STALL_CNT_DEFAULT = 16;

    // Encoding 3 is reserved and never driven.
    typedef enum logic [NB_FWD_SEL-1:0] {
        FWD_REGFILE = 2'd0,
        FWD_MEM     = 2'd1,
        FWD_WB      = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side signal bundle of the hazard/forwarding unit. The master drives the
// pipeline register contents; the slave is the unit itself.
interface hazard_forward_unit_if
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned NB_REG_ADDR  = NB_REG_ADDR_DEFAULT,
    parameter int unsigned NB_STALL_CNT = NB_STALL_CNT_DEFAULT
);
    logic                    i_valid;
    logic [NB_REG_ADDR-1:0]  i_id_rs;
    logic [NB_REG_ADDR-1:0]  i_id_rt;
    logic                    i_id_use_rs;
    logic                    i_id_use_rt;
    logic                    i_id_branch;
    logic                    i_ex_we;
    logic                    i_ex_re;
    logic [NB_REG_ADDR-1:0]  i_ex_rd;
    logic                    i_mem_we;
    logic                    i_mem_re;
    logic [NB_REG_ADDR-1:0]  i_mem_rd;
    logic                    i_wb_we;
    logic [NB_REG_ADDR-1:0]  i_wb_rd;
    logic                    i_cnt_clr;
    logic                    o_stall;
    logic [NB_FWD_SEL-1:0]   o_fwd_ex_a;
    logic [NB_FWD_SEL-1:0]   o_fwd_ex_b;
    logic [NB_FWD_SEL-1:0]   o_fwd_id_a;
    logic [NB_FWD_SEL-1:0]   o_fwd_id_b;
    logic [NB_STALL_CNT-1:0] o_stall_cycles;

    modport master (
        output i_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_branch,
               i_ex_we, i_ex_re, i_ex_rd, i_mem_we, i_mem_re, i_mem_rd,
               i_wb_we, i_wb_rd, i_cnt_clr,
        input  o_stall, o_fwd_ex_a, o_fwd_ex_b, o_fwd_id_a, o_fwd_id_b, o_stall_cycles
    );

    modport slave (
        input  i_valid, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_branch,
               i_ex_we, i_ex_re, i_ex_rd, i_mem_we, i_mem_re, i_mem_rd,
               i_wb_we, i_wb_rd, i_cnt_clr,
        output o_stall, o_fwd_ex_a, o_fwd_ex_b, o_fwd_id_a, o_fwd_id_b, o_stall_cycles
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select: two-source priority forwarding selector (MEM over WB); a zero source
// address never forwards.
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned NB_REG_ADDR = NB_REG_ADDR_DEFAULT
) (
    input  logic [NB_REG_ADDR-1:0] i_src,
    input  logic                   i_mem_we,
    input  logic [NB_REG_ADDR-1:0] i_mem_rd,
    input  logic                   i_wb_we,
    input  logic [NB_REG_ADDR-1:0] i_wb_rd,
    output fwd_sel_e               o_sel
);

    always_comb begin
        o_sel = FWD_REGFILE;
        if (i_src != '0) begin
            if (i_mem_we && (i_mem_rd == i_src)) begin
                o_sel = FWD_MEM;
            end else if (i_wb_we && (i_wb_rd == i_src)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use / branch hazard detection, operand forwarding and stall-cycle counter.
// HAZARD_FORWARD_EN enables forwarding; without it selects are 0 and RAW hazards stall.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned NB_REG_ADDR  = NB_REG_ADDR_DEFAULT,
    parameter int unsigned NB_STALL_CNT = NB_STALL_CNT_DEFAULT
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    hazard_forward_unit_if.slave bus
);

`ifdef HAZARD_FORWARD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    localparam logic [NB_STALL_CNT-1:0] CntOne = NB_STALL_CNT'(1);

    logic [NB_REG_ADDR-1:0]  id_rs_eff, id_rt_eff, id_br_rs, id_br_rt;
    logic [NB_REG_ADDR-1:0]  ex_rs_q, ex_rt_q;
    logic [NB_STALL_CNT-1:0] cnt_q, cnt_d;
    logic                    ex_hit, mem_hit, stall;
    logic                    mem_fwd_we, wb_fwd_we;
    fwd_sel_e                fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b;

    function automatic logic hit(logic [NB_REG_ADDR-1:0] rd, logic [NB_REG_ADDR-1:0] src);
        return (src != '0) && (rd == src);
    endfunction

    assign id_rs_eff = bus.i_id_use_rs ? bus.i_id_rs : '0;
    assign id_rt_eff = bus.i_id_use_rt ? bus.i_id_rt : '0;
    assign ex_hit    = hit(bus.i_ex_rd, id_rs_eff) || hit(bus.i_ex_rd, id_rt_eff);
    assign mem_hit   = hit(bus.i_mem_rd, id_rs_eff) || hit(bus.i_mem_rd, id_rt_eff);

    // Without forwarding every in-flight writer of an ID source must drain first.
    assign stall = (bus.i_ex_re && ex_hit)
                 || (bus.i_id_branch && bus.i_ex_we && ex_hit)
                 || (bus.i_id_branch && bus.i_mem_re && mem_hit)
                 || (!FwdEn && ((bus.i_ex_we && ex_hit) || (bus.i_mem_we && mem_hit)));

    // A load in MEM has no result yet, so it is never a forwarding source.
    assign mem_fwd_we = FwdEn && bus.i_mem_we && !bus.i_mem_re;
    assign wb_fwd_we  = FwdEn && bus.i_wb_we;
    assign id_br_rs   = bus.i_id_branch ? id_rs_eff : '0;
    assign id_br_rt   = bus.i_id_branch ? id_rt_eff : '0;

    hazard_forward_unit_fwd_select #(.NB_REG_ADDR(NB_REG_ADDR)) u_sel_ex_a (
        .i_src(ex_rs_q), .i_mem_we(mem_fwd_we), .i_mem_rd(bus.i_mem_rd),
        .i_wb_we(wb_fwd_we), .i_wb_rd(bus.i_wb_rd), .o_sel(fwd_ex_a)
    );
    hazard_forward_unit_fwd_select #(.NB_REG_ADDR(NB_REG_ADDR)) u_sel_ex_b (
        .i_src(ex_rt_q), .i_mem_we(mem_fwd_we), .i_mem_rd(bus.i_mem_rd),
        .i_wb_we(wb_fwd_we), .i_wb_rd(bus.i_wb_rd), .o_sel(fwd_ex_b)
    );
    hazard_forward_unit_fwd_select #(.NB_REG_ADDR(NB_REG_ADDR)) u_sel_id_a (
        .i_src(id_br_rs), .i_mem_we(mem_fwd_we), .i_mem_rd(bus.i_mem_rd),
        .i_wb_we(wb_fwd_we), .i_wb_rd(bus.i_wb_rd), .o_sel(fwd_id_a)
    );
    hazard_forward_unit_fwd_select #(.NB_REG_ADDR(NB_REG_ADDR)) u_sel_id_b (
        .i_src(id_br_rt), .i_mem_we(mem_fwd_we), .i_mem_rd(bus.i_mem_rd),
        .i_wb_we(wb_fwd_we), .i_wb_rd(bus.i_wb_rd), .o_sel(fwd_id_b)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (bus.i_valid) begin
            if (bus.i_cnt_clr) begin
                cnt_d = '0;
            end else if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (bus.i_valid) begin
                ex_rs_q <= stall ? '0 : id_rs_eff;
                ex_rt_q <= stall ? '0 : id_rt_eff;
            end
        end
    end

    assign bus.o_stall        = stall;
    assign bus.o_fwd_ex_a     = fwd_ex_a;
    assign bus.o_fwd_ex_b     = fwd_ex_b;
    assign bus.o_fwd_id_a     = fwd_id_a;
    assign bus.o_fwd_id_b     = fwd_id_b;
    assign bus.o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus random stimulus checked
// against a rule-level model; follows HAZARD_FORWARD_EN like the design.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.NB_REG_ADDR(5), .NB_STALL_CNT(16)) bus ();
    hazard_forward_unit_if #(.NB_REG_ADDR(5), .NB_STALL_CNT(2))  bus_sat ();

    assign bus_sat.i_valid     = bus.i_valid;
    assign bus_sat.i_id_rs     = bus.i_id_rs;
    assign bus_sat.i_id_rt     = bus.i_id_rt;
    assign bus_sat.i_id_use_rs = bus.i_id_use_rs;
    assign bus_sat.i_id_use_rt = bus.i_id_use_rt;
    assign bus_sat.i_id_branch = bus.i_id_branch;
    assign bus_sat.i_ex_we     = bus.i_ex_we;
    assign bus_sat.i_ex_re     = bus.i_ex_re;
    assign bus_sat.i_ex_rd     = bus.i_ex_rd;
    assign bus_sat.i_mem_we    = bus.i_mem_we;
    assign bus_sat.i_mem_re    = bus.i_mem_re;
    assign bus_sat.i_mem_rd    = bus.i_mem_rd;
    assign bus_sat.i_wb_we     = bus.i_wb_we;
    assign bus_sat.i_wb_rd     = bus.i_wb_rd;
    assign bus_sat.i_cnt_clr   = bus.i_cnt_clr;

    hazard_forward_unit #(.NB_REG_ADDR(5), .NB_STALL_CNT(16)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus)
    );
    hazard_forward_unit #(.NB_REG_ADDR(5), .NB_STALL_CNT(2)) u_dut_sat (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus_sat)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: what the EX stage currently holds and how many stalls were seen.
    logic [4:0]  m_ex_rs, m_ex_rt;
    int unsigned m_cnt, m_cnt_sat;
    bit          m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] eff(input logic [4:0] a, input logic use_it);
        return use_it ? a : 5'd0;
    endfunction

    function automatic bit same(input logic [4:0] rd, input logic [4:0] src);
        return (src != 5'd0) && (rd == src);
    endfunction

    function automatic bit exp_stall();
        logic [4:0] s [2];
        bit r = 1'b0;
        s[0] = eff(bus.i_id_rs, bus.i_id_use_rs);
        s[1] = eff(bus.i_id_rt, bus.i_id_use_rt);
        for (int i = 0; i < 2; i++) begin
            if (bus.i_ex_re && same(bus.i_ex_rd, s[i])) r = 1'b1;
            if (bus.i_id_branch && bus.i_ex_we && same(bus.i_ex_rd, s[i])) r = 1'b1;
            if (bus.i_id_branch && bus.i_mem_re && same(bus.i_mem_rd, s[i])) r = 1'b1;
            if (!FWD && bus.i_ex_we && same(bus.i_ex_rd, s[i])) r = 1'b1;
            if (!FWD && bus.i_mem_we && same(bus.i_mem_rd, s[i])) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] src);
        if (!FWD) return 2'd0;
        if (bus.i_mem_we && !bus.i_mem_re && same(bus.i_mem_rd, src)) return 2'd1;
        if (bus.i_wb_we && same(bus.i_wb_rd, src)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] exp_id_sel(input logic [4:0] a, input logic use_it);
        return bus.i_id_branch ? exp_sel(eff(a, use_it)) : 2'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex_rs   = '0;
            m_ex_rt   = '0;
            m_cnt     = 0;
            m_cnt_sat = 0;
        end else if (bus.i_valid) begin
            m_st = exp_stall();
            if (bus.i_cnt_clr) begin
                m_cnt     = 0;
                m_cnt_sat = 0;
            end else if (m_st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 3) m_cnt_sat++;
            end
            m_ex_rs = m_st ? 5'd0 : eff(bus.i_id_rs, bus.i_id_use_rs);
            m_ex_rt = m_st ? 5'd0 : eff(bus.i_id_rt, bus.i_id_use_rt);
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("stall", 32'(bus.o_stall), 32'(exp_stall()));
            chk("fwd_ex_a", 32'(bus.o_fwd_ex_a), 32'(exp_sel(m_ex_rs)));
            chk("fwd_ex_b", 32'(bus.o_fwd_ex_b), 32'(exp_sel(m_ex_rt)));
            chk("fwd_id_a", 32'(bus.o_fwd_id_a), 32'(exp_id_sel(bus.i_id_rs, bus.i_id_use_rs)));
            chk("fwd_id_b", 32'(bus.o_fwd_id_b), 32'(exp_id_sel(bus.i_id_rt, bus.i_id_use_rt)));
            chk("stall_cycles", 32'(bus.o_stall_cycles), m_cnt);
            chk("stall_cycles_sat", 32'(bus_sat.o_stall_cycles), m_cnt_sat);
            chk("ex_rs_shadow", 32'(u_dut.ex_rs_q), 32'(m_ex_rs));
            chk("ex_rt_shadow", 32'(u_dut.ex_rt_q), 32'(m_ex_rt));
        end
    end

    task automatic idle();
        bus.i_valid = 1'b1;
        bus.i_id_rs = '0; bus.i_id_rt = '0; bus.i_id_use_rs = 1'b0; bus.i_id_use_rt = 1'b0;
        bus.i_id_branch = 1'b0;
        bus.i_ex_we = 1'b0; bus.i_ex_re = 1'b0; bus.i_ex_rd = '0;
        bus.i_mem_we = 1'b0; bus.i_mem_re = 1'b0; bus.i_mem_rd = '0;
        bus.i_wb_we = 1'b0; bus.i_wb_rd = '0;
        bus.i_cnt_clr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("reset_stall", 32'(bus.o_stall), 0);
        chk("reset_cnt", 32'(bus.o_stall_cycles), 0);
        chk("reset_ex_rs", 32'(u_dut.ex_rs_q), 0);
        chk("reset_fwd_ex_a", 32'(bus.o_fwd_ex_a), 0);

        // Load-use: lw $5 in EX, add reading $5 in ID.
        cyc(); idle();
        bus.i_ex_re = 1'b1; bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd5;
        bus.i_id_rs = 5'd5; bus.i_id_use_rs = 1'b1;
        #2 chk("lu_stall", 32'(bus.o_stall), 1);
        cyc(); idle();
        #2 chk("lu_bubble", 32'(u_dut.ex_rs_q), 0);
        chk("lu_cnt", 32'(bus.o_stall_cycles), 1);

        // Load followed by a branch on the loaded register: two stall cycles.
        cyc(); idle();
        bus.i_ex_re = 1'b1; bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd3;
        bus.i_id_branch = 1'b1; bus.i_id_rs = 5'd3; bus.i_id_use_rs = 1'b1;
        #2 chk("lb_stall1", 32'(bus.o_stall), 1);
        cyc();
        bus.i_ex_re = 1'b0; bus.i_ex_we = 1'b0; bus.i_ex_rd = 5'd0;
        bus.i_mem_re = 1'b1; bus.i_mem_we = 1'b1; bus.i_mem_rd = 5'd3;
        #2 chk("lb_stall2", 32'(bus.o_stall), 1);
        cyc();
        bus.i_mem_re = 1'b0; bus.i_mem_we = 1'b0; bus.i_mem_rd = 5'd0;
        bus.i_wb_we = 1'b1; bus.i_wb_rd = 5'd3;
        #2 chk("lb_release", 32'(bus.o_stall), 0);
        chk("lb_fwd_id_a", 32'(bus.o_fwd_id_a), FWD ? 2 : 0);
        chk("lb_cnt", 32'(bus.o_stall_cycles), 3);

        // Saturation of the 2-bit counter, then reset in the middle of a stall.
        cyc(); idle();
        bus.i_ex_re = 1'b1; bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd6;
        bus.i_id_rs = 5'd6; bus.i_id_use_rs = 1'b1;
        #2 chk("sat_before", 32'(bus_sat.o_stall_cycles), 3);
        cyc();
        #2 chk("cnt_four", 32'(bus.o_stall_cycles), 4);
        chk("sat_hold", 32'(bus_sat.o_stall_cycles), 3);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_cnt", 32'(bus.o_stall_cycles), 0);
        chk("rst_async_sat", 32'(bus_sat.o_stall_cycles), 0);
        chk("rst_stall_comb", 32'(bus.o_stall), 1);
        cyc(); rst_n = 1'b1;
        cyc(); cyc();
        #2 chk("cnt_after_rst", 32'(bus.o_stall_cycles), 2);
        cyc(); bus.i_cnt_clr = 1'b1;
        cyc(); idle();
        #2 chk("cnt_clr", 32'(bus.o_stall_cycles), 0);

        // Debug halt: stall still visible, nothing counts.
        bus.i_valid = 1'b0;
        bus.i_ex_re = 1'b1; bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd2;
        bus.i_id_rs = 5'd2; bus.i_id_use_rs = 1'b1;
        cyc();
        #2 chk("halt_stall", 32'(bus.o_stall), 1);
        chk("halt_cnt", 32'(bus.o_stall_cycles), 0);

        // ALU forwarding with MEM and WB both writing $7.
        cyc(); idle();
        bus.i_id_rs = 5'd7; bus.i_id_use_rs = 1'b1;
        cyc(); idle();
        bus.i_mem_we = 1'b1; bus.i_mem_rd = 5'd7; bus.i_wb_we = 1'b1; bus.i_wb_rd = 5'd7;
        #2 chk("alu_shadow", 32'(u_dut.ex_rs_q), 7);
        chk("alu_mem_wins", 32'(bus.o_fwd_ex_a), FWD ? 1 : 0);
        #1 bus.i_mem_we = 1'b0;
        #1 chk("alu_wb", 32'(bus.o_fwd_ex_a), FWD ? 2 : 0);

        // Register zero never hazards or forwards.
        cyc(); idle();
        bus.i_ex_re = 1'b1; bus.i_ex_we = 1'b1; bus.i_ex_rd = 5'd0;
        bus.i_mem_we = 1'b1; bus.i_wb_we = 1'b1;
        bus.i_id_branch = 1'b1; bus.i_id_use_rs = 1'b1; bus.i_id_use_rt = 1'b1;
        #2 chk("zero_stall", 32'(bus.o_stall), 0);
        chk("zero_fwd_id_a", 32'(bus.o_fwd_id_a), 0);

        // ALU writer of $4 in MEM, non-branch reader in ID.
        cyc(); idle();
        bus.i_mem_we = 1'b1; bus.i_mem_rd = 5'd4;
        bus.i_id_rs = 5'd4; bus.i_id_use_rs = 1'b1;
        #2 chk("mem_raw_stall", 32'(bus.o_stall), FWD ? 0 : 1);
        chk("mem_raw_fwd_id_a", 32'(bus.o_fwd_id_a), 0);

        // Random traffic over a small register range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            bus.i_valid     = ($urandom_range(0, 9) != 0);
            bus.i_id_rs     = 5'($urandom_range(0, 7));
            bus.i_id_rt     = 5'($urandom_range(0, 7));
            bus.i_id_use_rs = 1'($urandom);
            bus.i_id_use_rt = 1'($urandom);
            bus.i_id_branch = ($urandom_range(0, 3) == 0);
            bus.i_ex_we     = 1'($urandom);
            bus.i_ex_re     = bus.i_ex_we && ($urandom_range(0, 2) == 0);
            bus.i_ex_rd     = 5'($urandom_range(0, 7));
            bus.i_mem_we    = 1'($urandom);
            bus.i_mem_re    = bus.i_mem_we && ($urandom_range(0, 2) == 0);
            bus.i_mem_rd    = 5'($urandom_range(0, 7));
            bus.i_wb_we     = 1'($urandom);
            bus.i_wb_rd     = 5'($urandom_range(0, 7));
            bus.i_cnt_clr   = ($urandom_range(0, 49) == 0);
        end

        cyc(); idle();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised successor to the pipeline hazard detector for the 5-stage MIPS core. Detects load-use and branch-operand hazards and asserts a stall. Generates forwarding selects for the EX-stage ALU operands and the ID-stage branch comparator. Keeps a saturating stall-cycle counter for the debug unit. Sits beside the ID stage; reads destination info from the EX, MEM and WB pipeline registers.

## Interface
- NB_REG_ADDR, 5, register address width
- NB_FWD_SEL, 2, forwarding select width (fixed encoding, see Operation)
- NB_STALL_CNT, 16, stall-cycle counter width
- i_clock  in  1  core clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  pipeline advance enable (debug step/run); state updates only when high
- i_id_rs, i_id_rt  in  NB_REG_ADDR  sources of the instruction in ID
- i_id_use_rs, i_id_use_rt  in  1  source actually read by the ID instruction
- i_id_branch  in  1  ID instruction is a branch or JR/JALR (operands consumed in ID)
- i_ex_we, i_ex_re  in  1  EX instruction writes a register / is a load
- i_ex_rd  in  NB_REG_ADDR  EX destination
- i_mem_we, i_mem_re  in  1  same for MEM
- i_mem_rd  in  NB_REG_ADDR  MEM destination
- i_wb_we  in  1  WB writes a register
- i_wb_rd  in  NB_REG_ADDR  WB destination
- i_cnt_clr  in  1  synchronous clear of the stall counter
- o_stall  out  1  freeze PC and IF/ID, inject a bubble into ID/EX
- o_fwd_ex_a, o_fwd_ex_b  out  NB_FWD_SEL  EX operand A/B select
- o_fwd_id_a, o_fwd_id_b  out  NB_FWD_SEL  ID branch-compare operand A/B select
- o_stall_cycles  out  NB_STALL_CNT  number of cycles with stall

## Operation
- Effective source: a source equals the ID address when its use flag is 1; otherwise it is 0. Register 0 never matches, is never forwarded, and never stalls.
- EX source registers ex_rs/ex_rt are internal shadows of the ID/EX sources. When i_valid is 1 and o_stall is 0, they load the effective ID sources. When i_valid is 1 and o_stall is 1, they load 0 (bubble). When i_valid is 0, they hold.
- Stall is the OR of three conditions:
  - Load-use: i_ex_re and i_ex_rd matches an effective ID source.
  - Branch after writer in EX: i_id_branch and i_ex_we and i_ex_rd matches.
  - Branch after load in MEM: i_id_branch and i_mem_re and i_mem_rd matches.
- Forwarding select encoding: 0 = register file, 1 = MEM result, 2 = WB result, 3 = reserved (never driven).
- EX selects use ex_rs/ex_rt:
  - MEM is chosen when i_mem_we, !i_mem_re and the addresses match.
  - Otherwise WB is chosen when i_wb_we and the addresses match.
  - Otherwise 0.
  - MEM has priority over WB.
- ID selects use the effective ID sources, are gated by i_id_branch, and follow the same MEM-over-WB rule. Otherwise they are 0.
- Counter: increments when i_valid and o_stall, and saturates at all-ones. i_cnt_clr has priority over increment.

## Timing
- o_stall and all forwarding selects are combinational from the inputs and the registered shadows. The stall takes effect in the same cycle.
- A load in EX followed by a branch in ID produces exactly 2 stall cycles: load-use first, then branch-after-load-in-MEM.
- Reset values: ex_rs = 0, ex_rt = 0, o_stall_cycles = 0. o_stall = 0 and all selects = 0 whenever the inputs are idle.
- Reset is asynchronous on assertion and takes effect immediately, including mid-stall. Release is synchronous to i_clock.
- When i_valid = 0, nothing updates and the outputs still reflect the current inputs.

## Configuration
- HAZARD_FORWARD_EN defined: full forwarding as described above.
- HAZARD_FORWARD_EN undefined:
  - All four selects are tied to 0.
  - o_stall additionally asserts on any effective ID source matching i_ex_rd (with i_ex_we) or i_mem_rd (with i_mem_we).
  - WB is assumed to write in the first half-cycle, so it needs no stall.

## Structure
- Shared package (core defines file) holds: the forwarding select encoding constants FWD_REGFILE, FWD_MEM, FWD_WB, and the default widths.
- One sub-module, fwd_select: a combinational 2-source priority selector with zero-register exclusion. It is instantiated four times.

## Test plan
- Load-use:
  - Stimulus: EX = lw $5 (re=1, we=1, rd=5); ID = add with rs=5 used.
  - Response: o_stall=1 for 1 cycle; next cycle ex_rs=0 (bubble); o_stall_cycles=1.
- Load then branch:
  - Stimulus: EX = lw rd=3; ID = beq rs=3, held across the stall.
  - Response: stall for 2 cycles, then o_fwd_id_a=2 once the load is in WB.
- ALU forwarding:
  - Stimulus: MEM we rd=7 and WB we rd=7; EX shadow rs=7.
  - Response: o_fwd_ex_a=1 (MEM wins); with MEM we=0, the response is 2.
- Zero register:
  - Stimulus: EX = lw rd=0; ID rs=0 used.
  - Response: o_stall=0 and all selects 0.
- Reset and counter:
  - Stimulus: force 3 stalls, then assert i_reset_n=0 mid-stall.
  - Response: o_stall_cycles drops to 0 immediately; i_cnt_clr also zeroes the counter; with NB_STALL_CNT=2, the counter saturates at 3.
- Macro off:
  - Stimulus: MEM we rd=4 with ID rs=4 used.
  - Response: o_stall=1 and selects 0.
